// File: rtl/priority_encoder_serial.sv
// Serial priority encoder: accepts an N-bit request vector and emits
// the index of every set bit, one registered beat per handshake.
module priority_encoder_serial #(
  parameter int unsigned N         = 8,
  parameter int unsigned IDX_W     = 3,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic [IDX_W:0]   out_count
);

  localparam int unsigned CW = IDX_W + 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  if (N < 2 || N > 256) begin : g_bad_n
    $fatal(1, "priority_encoder_serial: N out of range 2..256");
  end

  if (IDX_W != $clog2(N)) begin : g_bad_w
    $fatal(1, "priority_encoder_serial: IDX_W must equal clog2(N)");
  end

  logic           state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic           valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic           last_q, last_d;
  logic           zero_q, zero_d;
  logic [CW-1:0]  count_q, count_d;
  logic [N-1:0]   cleared;

  function automatic logic [IDX_W-1:0] pick(input logic [N-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < int'(N); i++) begin
        if (m[i]) r = IDX_W'(i);
      end
    end else begin
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (m[i]) r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(N); i++) begin
      c = c + CW'(m[i]);
    end
    return c;
  endfunction

  function automatic logic one_left(input logic [N-1:0] m);
    return (m != '0) && ((m & (m - ONE)) == '0);
  endfunction

  // Next-state: load on accept, retire one bit per output handshake
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    last_d  = last_q;
    zero_d  = zero_q;
    count_d = count_q;
    cleared = mask_q & ~(ONE << idx_q);
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (in_valid) begin
          state_d = ST_EMIT;
          mask_d  = in_vec;
          valid_d = 1'b1;
          idx_d   = pick(in_vec);
          zero_d  = (in_vec == '0);
          last_d  = (in_vec == '0) || one_left(in_vec);
          count_d = popcnt(in_vec);
        end
      end
      (state_q == ST_EMIT): begin
        if (out_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            valid_d = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
            zero_d  = 1'b0;
            count_d = '0;
          end else begin
            mask_d = cleared;
            idx_d  = pick(cleared);
            last_d = one_left(cleared);
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = rst_n && (state_q == ST_IDLE);
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_zero  = zero_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_priority_encoder_serial.sv
// Scoreboard bench: three encoder configurations driven with directed
// and random vectors, expected beats from a scan-based reference.
module tb_priority_encoder_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv[3];
  logic [31:0] vec[3];
  logic        ordy[3];

  logic ir_0, ov_0, ol_0, oz_0;
  logic [2:0] oi_0;
  logic [3:0] oc_0;
  logic ir_1, ov_1, ol_1, oz_1;
  logic [2:0] oi_1;
  logic [3:0] oc_1;
  logic ir_2, ov_2, ol_2, oz_2;
  logic [4:0] oi_2;
  logic [5:0] oc_2;

  logic ir[3], ov[3], ol[3], oz[3];
  int   oi[3], oc[3];

  always_comb begin
    ir[0] = ir_0; ov[0] = ov_0; ol[0] = ol_0; oz[0] = oz_0;
    oi[0] = int'(oi_0); oc[0] = int'(oc_0);
    ir[1] = ir_1; ov[1] = ov_1; ol[1] = ol_1; oz[1] = oz_1;
    oi[1] = int'(oi_1); oc[1] = int'(oc_1);
    ir[2] = ir_2; ov[2] = ov_2; ol[2] = ol_2; oz[2] = oz_2;
    oi[2] = int'(oi_2); oc[2] = int'(oc_2);
  end

  priority_encoder_serial #(.N(8), .IDX_W(3), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir_0), .in_vec(vec[0][7:0]),
    .out_valid(ov_0), .out_ready(ordy[0]), .out_idx(oi_0),
    .out_last(ol_0), .out_zero(oz_0), .out_count(oc_0)
  );

  priority_encoder_serial #(.N(8), .IDX_W(3), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir_1), .in_vec(vec[1][7:0]),
    .out_valid(ov_1), .out_ready(ordy[1]), .out_idx(oi_1),
    .out_last(ol_1), .out_zero(oz_1), .out_count(oc_1)
  );

  priority_encoder_serial #(.N(32), .IDX_W(5), .MSB_FIRST(1'b0)) u_wide (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[2]), .in_ready(ir_2), .in_vec(vec[2]),
    .out_valid(ov_2), .out_ready(ordy[2]), .out_idx(oi_2),
    .out_last(ol_2), .out_zero(oz_2), .out_count(oc_2)
  );

  typedef struct {
    int idx;
    bit last;
    bit zero;
    int cnt;
  } beat_t;

  beat_t sb[3][$];
  int errors = 0;
  int checks = 0;
  int pops[3] = '{0, 0, 0};
  int mode[3] = '{0, 0, 0};
  int NW[3]   = '{8, 8, 32};
  bit MSB[3]  = '{1'b0, 1'b1, 1'b0};

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: list the set bit positions, order them, one beat each
  task automatic model(int d, logic [31:0] v);
    int idxs[$];
    int cnt;
    for (int i = 0; i < NW[d]; i++) begin
      if (v[i]) idxs.push_back(i);
    end
    if (MSB[d]) idxs.reverse();
    cnt = idxs.size();
    if (cnt == 0) begin
      sb[d].push_back('{0, 1'b1, 1'b1, 0});
    end else begin
      foreach (idxs[k]) begin
        sb[d].push_back('{idxs[k], (k == cnt - 1), 1'b0, cnt});
      end
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    for (int d = 0; d < 3; d++) ordy[d] = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 3; d++) begin
        if (mode[d] == 0) ordy[d] = 1'b1;
        else if (mode[d] == 1) ordy[d] = 1'($urandom_range(0, 1));
        else ordy[d] = 1'b0;
      end
    end
  end

  // Monitor: pops on every handshake, checks stability while stalled
  initial begin : mon
    beat_t e;
    beat_t p[3];
    bit hold[3];
    bit r;
    for (int d = 0; d < 3; d++) hold[d] = 1'b0;
    forever begin
      @(posedge clk);
      r = rst_n;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!r) hold[d] = 1'b0;
        if (hold[d]) begin
          chk($sformatf("d%0d_hold_valid", d), int'(ov[d]), 1);
          chk($sformatf("d%0d_hold_idx", d), oi[d], p[d].idx);
          chk($sformatf("d%0d_hold_last", d), int'(ol[d]), int'(p[d].last));
          chk($sformatf("d%0d_hold_zero", d), int'(oz[d]), int'(p[d].zero));
          chk($sformatf("d%0d_hold_count", d), oc[d], p[d].cnt);
        end
        if (ov[d] && ordy[d]) begin
          if (sb[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d%0d_unexpected_beat: got idx %0d expected no beat",
                     d, oi[d]);
          end else begin
            e = sb[d].pop_front();
            chk($sformatf("d%0d_idx", d), oi[d], e.idx);
            chk($sformatf("d%0d_last", d), int'(ol[d]), int'(e.last));
            chk($sformatf("d%0d_zero", d), int'(oz[d]), int'(e.zero));
            chk($sformatf("d%0d_count", d), oc[d], e.cnt);
          end
          pops[d]++;
        end
        hold[d] = ov[d] && !ordy[d];
        p[d] = '{oi[d], ol[d], oz[d], oc[d]};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int d, logic [31:0] v);
    int t = 0;
    while (!ir[d] && t < 200) begin
      tick();
      t++;
    end
    if (!ir[d]) begin
      checks++;
      errors++;
      $display("FAIL d%0d_accept_timeout: got in_ready 0 expected 1", d);
      return;
    end
    iv[d]  = 1'b1;
    vec[d] = v;
    model(d, v);
    tick();
    iv[d]  = 1'b0;
    vec[d] = $urandom;
  endtask

  task automatic drain(int d);
    int t = 0;
    while ((sb[d].size() != 0 || ov[d]) && t < 400) begin
      tick();
      t++;
    end
    chk($sformatf("d%0d_drain_left", d), sb[d].size(), 0);
  endtask

  initial begin
    int p0;
    int t;
    logic [31:0] v;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d]  = 1'b0;
      vec[d] = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_rst_ready", d), int'(ir[d]), 0);
      chk($sformatf("d%0d_rst_valid", d), int'(ov[d]), 0);
      chk($sformatf("d%0d_rst_idx", d), oi[d], 0);
      chk($sformatf("d%0d_rst_last", d), int'(ol[d]), 0);
      chk($sformatf("d%0d_rst_zero", d), int'(oz[d]), 0);
      chk($sformatf("d%0d_rst_count", d), oc[d], 0);
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d_post_rst_ready", d), int'(ir[d]), 1);
    end

    // one-hot sweep
    for (int i = 0; i < 8; i++) begin
      send(0, 32'(1) << i);
      chk("onehot_latency_valid", int'(ov[0]), 1);
      chk("onehot_busy_ready", int'(ir[0]), 0);
      tick();
      chk("onehot_ready_back", int'(ir[0]), 1);
      chk("onehot_valid_drop", int'(ov[0]), 0);
    end

    // multi-hot, both orders, consecutive beats
    send(0, 32'h52);
    chk("mh_lsb_b0", oi[0], 1);
    tick();
    chk("mh_lsb_b1", oi[0], 4);
    tick();
    chk("mh_lsb_b2", oi[0], 6);
    chk("mh_lsb_last", int'(ol[0]), 1);
    drain(0);
    send(1, 32'h52);
    chk("mh_msb_b0", oi[1], 6);
    tick();
    chk("mh_msb_b1", oi[1], 4);
    tick();
    chk("mh_msb_b2", oi[1], 1);
    chk("mh_msb_last", int'(ol[1]), 1);
    drain(1);

    // back-pressure with a rejected second vector
    mode[0] = 2;
    send(0, 32'h81);
    iv[0]  = 1'b1;
    vec[0] = 32'hFF;
    chk("bp_ready_low", int'(ir[0]), 0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", int'(ov[0]), 1);
      chk("bp_idx", oi[0], 0);
      tick();
    end
    iv[0] = 1'b0;
    mode[0] = 0;
    drain(0);

    // zero vector
    send(0, 32'h0);
    drain(0);
    chk("zero_idle_ready", int'(ir[0]), 1);

    // reset mid-operation
    p0 = pops[0];
    send(0, 32'hFF);
    t = 0;
    while (pops[0] < p0 + 3 && t < 50) begin
      tick();
      t++;
    end
    chk("rst_mid_beats", pops[0] - p0, 3);
    rst_n   = 1'b0;
    mode[0] = 2;
    tick();
    sb[0].delete();
    chk("rst_mid_valid", int'(ov[0]), 0);
    chk("rst_mid_last", int'(ol[0]), 0);
    rst_n   = 1'b1;
    mode[0] = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_mid_quiet", int'(ov[0]), 0);
    end
    send(0, 32'h4);
    chk("rst_mid_new_idx", oi[0], 2);
    drain(0);

    // wide configuration with random out_ready
    mode[2] = 1;
    p0 = pops[2];
    send(2, 32'h8000_0001);
    drain(2);
    chk("wide_beats", pops[2] - p0, 2);

    // random traffic on all three configurations
    for (int d = 0; d < 3; d++) begin
      mode[d] = 1;
      for (int k = 0; k < 15; k++) begin
        v = $urandom;
        if (NW[d] == 8) v = v & 32'hFF;
        if ($urandom_range(0, 7) == 0) v = '0;
        send(d, v);
      end
      drain(d);
      mode[d] = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_encoder_serial.md
Name: priority_encoder_serial

Overview:
Parametrised, sequential successor of the combinational 8-to-3 encoder. It accepts an N-bit request vector through a valid/ready handshake. It then emits the binary index of every set bit, one per output beat, in a fixed priority order, with a last flag on the final beat. An all-zero vector produces one flagged beat. Multi-hot inputs are encoded completely rather than ambiguously. The block sits between request/interrupt collectors and downstream index consumers such as arbiters, dispatchers or software-visible FIFOs.

Parameters:
N, 8, width of the input vector; legal range 2..256.
IDX_W, 3, output index width; must equal ceil(log2(N)); checked at elaboration, with a fatal error on mismatch.
MSB_FIRST, 0, emission order: 0 emits the lowest set index first, 1 emits the highest set index first.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  in  1  in_vec is valid.
in_ready  out  1  block can accept a vector this cycle.
in_vec  in  N  request vector; bit i set means index i is to be emitted.
out_valid  out  1  out_idx, out_last and out_zero are valid.
out_ready  in  1  downstream accepts the current beat.
out_idx  out  IDX_W  binary index of the current set bit.
out_last  out  1  current beat is the final beat for this vector.
out_zero  out  1  the accepted vector was all-zero; beat carries no index.
out_count  out  IDX_W+1  number of set bits in the accepted vector; held constant for all beats of that vector.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE and the pending mask is cleared.
  - Outputs: in_ready=0 during reset, then 1 from the first cycle after reset deasserts.
  - out_valid=0, out_idx=0, out_last=0, out_zero=0, out_count=0.
  - Reset mid-operation discards all remaining bits; no further beats are emitted.
- States: IDLE, EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid && in_ready, in_vec is loaded into the pending mask, popcount(in_vec) into out_count, and the state moves to EMIT.
  - The first beat has out_valid=1 on the next cycle, so accept-to-first-beat latency is 1 cycle.
- EMIT:
  - in_ready=0; new vectors are back-pressured.
  - out_idx is the lowest set bit of the pending mask (MSB_FIRST=0) or the highest (MSB_FIRST=1).
  - out_last=1 when exactly one bit remains pending.
  - On out_valid && out_ready, the emitted bit is cleared from the mask and the next index appears on the following cycle.
  - If out_ready=0, out_idx, out_last, out_zero and out_count hold stable; out_valid is never withdrawn once asserted.
- All-zero vector: exactly one beat with out_zero=1, out_last=1, out_idx=0, out_count=0.
- After the beat with out_last=1 is handshaken:
  - The state returns to IDLE, so in_ready=1 on the next cycle.
  - There is no accept in the same cycle as the last handshake, so there is one bubble cycle between vectors.
  - Throughput is one beat per cycle within a vector and popcount+1 cycles per vector at full out_ready.
- out_count saturates at nothing; IDX_W+1 bits always hold N.
- Output registers hold all outputs (out_valid, out_idx, out_last, out_zero, out_count); the in_vec to out_idx path is never combinational.
- For a one-hot input, the single beat carries out_last=1 and the same index as the legacy 8-to-3 encoder.
- X or Z on in_vec while in_valid=0 is ignored.

Test Plan:
- One-hot sweep, N=8, MSB_FIRST=0, out_ready=1: for each i=0..7, in_vec=1<<i gives one beat with out_idx=i, out_last=1, out_count=1, and in_ready back to 1 two cycles after the accept.
- Multi-hot in_vec=8'b01010010, out_ready=1:
  - MSB_FIRST=0 gives beats out_idx=1,4,6 on consecutive cycles, out_last only on 6, out_count=3 on all beats.
  - MSB_FIRST=1 gives 6,4,1.
- Back-pressure with in_vec=8'b10000001 and out_ready held 0 for 3 cycles: out_valid=1 and out_idx=0 are held stable. Then out_ready=1 gives idx 0, then 7 with out_last=1. A second in_valid during EMIT is not accepted (in_ready=0).
- Zero vector 8'b00000000: one beat with out_zero=1, out_last=1, out_idx=0, out_count=0. Then IDLE.
- Reset mid-operation: in_vec=8'hFF is accepted, 3 beats are handshaken, and rst_n=0 is applied for 1 cycle. Required response: out_valid=0 from the cycle after the reset edge, no residual indices after release, and a new vector 8'b00000100 yields idx=2 only.
- Wide configuration N=32, IDX_W=5, MSB_FIRST=0, in_vec=32'h8000_0001 with random out_ready: beats 0 then 31, out_count=2. The bench checks the full index sequence against a popcount/scan reference model.
